fetch_queue: RTL and testbench

Instruction fetch stage for the RISC-V core, sitting directly upstream of the main decoder. It owns the program counter and issues word requests to instruction memory over a grant/response handshake. Returned words are held in a 2-entry in-order queue and presented to decode with a valid/ready handshake. A redirect from execute (taken branch, jal, jalr) discards the queue and any in-flight responses.

---
 rtl/fetch_queue.sv | 170 +++++++++++++++++
 tb/tb_fetch_queue.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : Instruction fetch stage. Owns the PC, issues word requests over
//             a grant/response handshake and buffers returned words in a
//             2-entry in-order queue toward decode. Optional misaligned
//             redirect trap is enabled by defining FETCH_MISALIGN_TRAP_EN.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        fetch_misalign
);

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic [31:0] r_pc;
    logic        r_head;
    logic        r_tail;
    logic [1:0]  r_alloc;
    logic [1:0]  r_filled;
    logic [31:0] r_slot_pc    [2];
    logic [31:0] r_slot_instr [2];
    logic [2:0]  r_drop_cnt;

    logic        w_halt;
    logic        w_full;
    logic        w_grant;
    logic        w_head_valid;
    logic        w_pop;
    logic        w_drop;
    logic        w_fill_idx;
    logic        w_fill;
    logic [2:0]  w_unfilled;
    logic [2:0]  w_drop_next;
    logic [31:0] w_redirect_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_halt;
    logic r_misalign;
    logic w_misalign_evt;

    assign w_misalign_evt = redirect && (redirect_pc[1:0] != 2'b00);
    assign w_halt         = r_halt;
    assign fetch_misalign = r_misalign;
    assign w_redirect_pc  = {redirect_pc[31:2], 2'b00};

    // Sticky until reset: a misaligned target stops all further fetching.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_halt     <= 1'b0;
            r_misalign <= 1'b0;
        end else if (w_misalign_evt) begin
            r_halt     <= 1'b1;
            r_misalign <= 1'b1;
        end
    end
`else
    logic w_unused_lsbs;

    assign w_unused_lsbs  = ^redirect_pc[1:0];
    assign w_halt         = 1'b0;
    assign fetch_misalign = 1'b0;
    assign w_redirect_pc  = {redirect_pc[31:2], 2'b00};
`endif

    assign w_full       = &r_alloc;
    assign imem_req     = !rst && !w_halt && !redirect && !w_full;
    assign imem_addr    = r_pc;
    assign w_grant      = imem_req && imem_gnt;

    assign w_head_valid = r_alloc[r_head] && r_filled[r_head];
    assign w_pop        = w_head_valid && id_ready;

    // Slots fill in allocation order, so the oldest unfilled one is either
    // the head or the slot right behind it.
    assign w_fill_idx   = (r_alloc[r_head] && !r_filled[r_head]) ? r_head : ~r_head;
    assign w_drop       = imem_rvalid && (r_drop_cnt != 3'd0);
    assign w_fill       = imem_rvalid && !w_drop && !redirect
                          && r_alloc[w_fill_idx] && !r_filled[w_fill_idx];

    assign w_unfilled   = {2'b00, r_alloc[0] & ~r_filled[0]}
                        + {2'b00, r_alloc[1] & ~r_filled[1]};

    // On redirect every outstanding response (pending drops plus unfilled
    // slots) becomes stale; the one arriving this cycle is discarded now.
    always_comb begin
        w_drop_next = r_drop_cnt;
        if (redirect) begin
            w_drop_next = r_drop_cnt + w_unfilled - {2'b00, imem_rvalid};
        end else if (w_drop) begin
            w_drop_next = r_drop_cnt - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_head     <= 1'b0;
            r_tail     <= 1'b0;
            r_drop_cnt <= 3'd0;
        end else begin
            r_drop_cnt <= w_drop_next;
            if (redirect) begin
                r_pc   <= w_redirect_pc;
                r_head <= 1'b0;
                r_tail <= 1'b0;
            end else begin
                if (w_grant) begin
                    r_pc   <= r_pc + 32'd4;
                    r_tail <= ~r_tail;
                end
                if (w_pop) begin
                    r_head <= ~r_head;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alloc  <= 2'b00;
            r_filled <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_slot_pc[i]    <= 32'd0;
                r_slot_instr[i] <= c_NOP;
            end
        end else if (redirect) begin
            r_alloc  <= 2'b00;
            r_filled <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_grant && (r_tail == 1'(i))) begin
                    r_alloc[i]   <= 1'b1;
                    r_filled[i]  <= 1'b0;
                    r_slot_pc[i] <= r_pc;
                end else if (w_pop && (r_head == 1'(i))) begin
                    r_alloc[i]  <= 1'b0;
                    r_filled[i] <= 1'b0;
                end
                if (w_fill && (w_fill_idx == 1'(i))) begin
                    r_filled[i]     <= 1'b1;
                    r_slot_instr[i] <= imem_rdata;
                end
            end
        end
    end

    assign id_valid    = w_head_valid;
    assign id_instr    = w_head_valid ? r_slot_instr[r_head] : c_NOP;
    assign id_pc       = r_slot_pc[r_head];
    assign id_pc_plus4 = id_pc + 32'd4;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_queue
//  Purpose  : Randomized self-checking bench for fetch_queue against a
//             queue-based reference model and an in-order memory model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_queue;

    localparam logic [31:0] c_NOP = 32'h0000_0013;
    localparam logic [31:0] c_KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        fetch_misalign;

    always #5 clk = ~clk;

    fetch_queue #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .fetch_misalign (fetch_misalign)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: PC, queue of in-order entries, stale flag per response.
    logic [31:0] m_pc;
    logic        m_halt;
    logic        m_mis;
    logic [31:0] mq_pc     [$];
    logic [31:0] mq_instr  [$];
    logic        mq_filled [$];
    logic        m_stale   [$];

    // Memory environment
    int          mem_due  [$];
    logic [31:0] mem_addr [$];
    int          cyc;
    int          last_due;
    int          lat;
    int          gnt_pct;
    int          rdy_pct;
    int          redir_pct;
    bit          redir_busy;
    int          redir_idx;

    // What decode actually consumed from the DUT
    logic [31:0] dut_pc  [$];
    logic [31:0] dut_pc4 [$];
    logic        obs_req;
    logic [31:0] obs_addr;

    task automatic model_clear();
        mq_pc.delete(); mq_instr.delete(); mq_filled.delete(); m_stale.delete();
        mem_due.delete(); mem_addr.delete(); dut_pc.delete(); dut_pc4.delete();
        m_pc = 32'd0; m_halt = 1'b0; m_mis = 1'b0;
        cyc = 0; last_due = 0; redir_idx = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; id_ready = 1'b0; redirect = 1'b0;
        @(negedge clk);
        #1;
        check_eq("rst_req",   imem_req, 1'b0);
        check_eq("rst_valid", id_valid, 1'b0);
        check_eq("rst_instr", id_instr, c_NOP);
        check_eq("rst_pc",    id_pc, 32'd0);
        check_eq("rst_pc4",   id_pc_plus4, 32'd4);
        check_eq("rst_mis",   fetch_misalign, 1'b0);
        model_clear();
    endtask

    task automatic step(input bit do_redir, input logic [31:0] tgt_in);
        bit          rv, g, r, rdir, ev, er, st;
        logic [31:0] rd, tgt;
        int          due;
        tgt = tgt_in;
        @(negedge clk);
        rst = 1'b0;
        cyc++;
        rv = (mem_due.size() > 0) && (mem_due[0] <= cyc);
        rd = $urandom;
        if (rv) begin
            rd = mem_addr[0] ^ c_KEY;
            void'(mem_due.pop_front());
            void'(mem_addr.pop_front());
        end
        ev = (mq_pc.size() > 0) && mq_filled[0];
        r  = ($urandom_range(99) < rdy_pct);
        g  = ($urandom_range(99) < gnt_pct);
        rdir = do_redir;
        if (redir_busy && rv && ev && r) begin
            rdir = 1'b1;
            redir_busy = 1'b0;
            redir_idx = dut_pc.size() + 1;
        end
        if (!rdir && redir_pct > 0 && $urandom_range(99) < redir_pct) begin
            rdir = 1'b1;
            tgt = $urandom;
            if ($urandom_range(3) != 0) tgt[1:0] = 2'b00;
        end
        imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
        id_ready = r; redirect = rdir; redirect_pc = tgt;
        #1;
        er = !m_halt && !rdir && (mq_pc.size() < 2);
        obs_req = imem_req; obs_addr = imem_addr;
        check_eq("imem_req", imem_req, er);
        if (er) check_eq("imem_addr", imem_addr, m_pc);
        check_eq("id_valid", id_valid, ev);
        if (ev) begin
            check_eq("id_pc",       id_pc, mq_pc[0]);
            check_eq("id_instr",    id_instr, mq_instr[0]);
            check_eq("id_pc_plus4", id_pc_plus4, mq_pc[0] + 32'd4);
        end else begin
            check_eq("id_instr_nop", id_instr, c_NOP);
        end
        check_eq("fetch_misalign", fetch_misalign, m_mis);
        if (id_valid && r) begin
            dut_pc.push_back(id_pc);
            dut_pc4.push_back(id_pc_plus4);
        end
        // Memory accepts what the DUT actually requests
        if (imem_req && g) begin
            due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            last_due = due;
            mem_due.push_back(due);
            mem_addr.push_back(imem_addr);
        end
        // Model update
        if (rdir) foreach (m_stale[i]) m_stale[i] = 1'b1;
        if (rv && m_stale.size() > 0) begin
            st = m_stale.pop_front();
            if (!st) begin
                for (int i = 0; i < mq_pc.size(); i++) begin
                    if (!mq_filled[i]) begin
                        mq_filled[i] = 1'b1;
                        mq_instr[i]  = rd;
                        break;
                    end
                end
            end
        end
        if (ev && r) begin
            void'(mq_pc.pop_front()); void'(mq_instr.pop_front()); void'(mq_filled.pop_front());
        end
        if (rdir) begin
            mq_pc.delete(); mq_instr.delete(); mq_filled.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
            if (tgt[1:0] != 2'b00) begin
                m_halt = 1'b1;
                m_mis  = 1'b1;
            end
`endif
            m_pc = {tgt[31:2], 2'b00};
        end else if (er && g) begin
            mq_pc.push_back(m_pc); mq_instr.push_back(32'd0); mq_filled.push_back(1'b0);
            m_stale.push_back(1'b0);
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        redir_pct = 0; redir_busy = 1'b0; lat = 1; gnt_pct = 100; rdy_pct = 100;
        model_clear();

        // Stream: 1-cycle memory, always granted, decode always ready
        do_reset();
        run(20);
        check_eq("stream_count_nz", (dut_pc.size() >= 6), 1'b1);
        for (int i = 0; i < dut_pc.size() && i < 6; i++) begin
            check_eq("stream_pc", dut_pc[i], 32'(4 * i));
        end

        // Backpressure then a single pop
        do_reset();
        rdy_pct = 0;
        run(6);
        check_eq("bp_req_low", obs_req, 1'b0);
        check_eq("bp_head_pc", id_pc, 32'd0);
        rdy_pct = 100;
        run(1);
        rdy_pct = 0;
        run(1);
        check_eq("bp_reissue_req",  obs_req, 1'b1);
        check_eq("bp_reissue_addr", obs_addr, 32'd8);

        // Redirect with two requests in flight on a 3-cycle memory
        do_reset();
        lat = 3; rdy_pct = 100;
        run(2);
        step(1'b1, 32'h0000_0100);
        run(1);
        check_eq("redir_next_addr", obs_addr, 32'h0000_0100);
        run(12);
        check_eq("redir_consumed", (dut_pc.size() > 0), 1'b1);
        if (dut_pc.size() > 0) check_eq("redir_first_pc", dut_pc[0], 32'h0000_0100);

        // Redirect coinciding with a fill and a pop
        do_reset();
        lat = 1;
        redir_busy = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0000_0200);
        redir_busy = 1'b0;
        run(10);
        check_eq("busy_fired", (redir_idx >= 0 && dut_pc.size() > redir_idx), 1'b1);
        if (redir_idx >= 0 && dut_pc.size() > redir_idx) begin
            for (int i = 0; i < redir_idx; i++) check_eq("busy_pre_pc", dut_pc[i], 32'(4 * i));
            check_eq("busy_post_pc", dut_pc[redir_idx], 32'h0000_0200);
        end

        // Wrap of the PC at 2^32
        do_reset();
        step(1'b1, 32'hFFFF_FFFC);
        run(10);
        check_eq("wrap_count", (dut_pc.size() >= 2), 1'b1);
        if (dut_pc.size() >= 2) begin
            check_eq("wrap_pc0",  dut_pc[0],  32'hFFFF_FFFC);
            check_eq("wrap_pc4",  dut_pc4[0], 32'h0000_0000);
            check_eq("wrap_pc1",  dut_pc[1],  32'h0000_0000);
        end

        // Misaligned redirect target
        do_reset();
        run(3);
        step(1'b1, 32'h0000_0102);
        run(8);
`ifdef FETCH_MISALIGN_TRAP_EN
        check_eq("mis_flag", fetch_misalign, 1'b1);
        check_eq("mis_req",  obs_req, 1'b0);
`else
        check_eq("mis_flag", fetch_misalign, 1'b0);
        check_eq("mis_count", (dut_pc.size() > 0), 1'b1);
        begin
            int k;
            k = -1;
            foreach (dut_pc[i]) if (k < 0 && dut_pc[i] >= 32'h100) k = i;
            check_eq("mis_found", (k >= 0), 1'b1);
            if (k >= 0) check_eq("mis_first_pc", dut_pc[k], 32'h0000_0100);
        end
`endif

        // Randomized traffic
        for (int round = 0; round < 20; round++) begin
            do_reset();
            lat       = $urandom_range(1, 3);
            gnt_pct   = $urandom_range(30, 100);
            rdy_pct   = $urandom_range(20, 100);
            redir_pct = $urandom_range(0, 8);
            run(150);
        end
        redir_pct = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
